// File: rtl/fdc_wd_rd_shaper.sv
// ---------------------------------------------------------------------------
// fdc_wd_rd_shaper
// Floppy data-path conditioner between the WD1793-compatible controller and
// the drive. All timing is in clk28 ticks.
//   Write path: vg_wd rising edges become active-low fd_wdat pulses delayed by
//   NOM_DLY, or by NOM_DLY -/+ PRECOMP on inner tracks (early/late shift).
//   Up to DEPTH pulses can be pending at once.
//   Read path: fd_rdat falling edges become vg_rawr pulses. A free-running
//   vg_rclk window is re-phased on each read edge so that the pulse sits
//   mid-window.
// Ports:
//   clk28      in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   path enable (0 = idle outputs, pending pulses discarded)
//   hd         in   high-density rate select for vg_rclk (period halves)
//   precomp_en in   1 = honour vg_tr43/vg_sl/vg_sr, 0 = always nominal delay
//   vg_wd      in   controller write-data strobe (async, active-high)
//   vg_sl      in   controller shift-left / early (async)
//   vg_sr      in   controller shift-right / late (async)
//   vg_tr43    in   controller track>43 flag (async)
//   fd_wdat    out  drive write data, active-low pulse
//   fd_rdat    in   drive read data (async, active-low)
//   vg_rawr    out  raw read pulse to controller, active-high
//   vg_rclk    out  read clock window to controller
//   wr_ovf     out  sticky: write edge dropped because every slot was busy
//   ovf_clr    in   single-cycle clear of wr_ovf (a coincident overflow wins)
// ---------------------------------------------------------------------------
module fdc_wd_rd_shaper #(
   parameter int unsigned CW       = 8,
   parameter int unsigned NOM_DLY  = 16,
   parameter int unsigned PRECOMP  = 4,
   parameter int unsigned WPULSE_W = 14,
   parameter int unsigned RPULSE_W = 14,
   parameter int unsigned RCLK_PER = 112,
   parameter int unsigned DEPTH    = 2
) (
   input  logic clk28,
   input  logic rst,
   input  logic en,
   input  logic hd,
   input  logic precomp_en,
   input  logic vg_wd,
   input  logic vg_sl,
   input  logic vg_sr,
   input  logic vg_tr43,
   output logic fd_wdat,
   input  logic fd_rdat,
   output logic vg_rawr,
   output logic vg_rclk,
   output logic wr_ovf,
   input  logic ovf_clr
);

   // ---------------- elaboration-time parameter checks ----------------
   if (CW < 2 || CW > 30) begin : g_chk_cw
      $error("fdc_wd_rd_shaper: CW out of range");
   end
   if (PRECOMP >= NOM_DLY) begin : g_chk_early
      $error("fdc_wd_rd_shaper: PRECOMP must be below NOM_DLY");
   end
   if (NOM_DLY + PRECOMP >= (1 << CW)) begin : g_chk_late
      $error("fdc_wd_rd_shaper: NOM_DLY+PRECOMP does not fit in CW bits");
   end
   if (WPULSE_W < 1 || WPULSE_W > (1 << CW)) begin : g_chk_wpw
      $error("fdc_wd_rd_shaper: WPULSE_W out of range");
   end
   if (RPULSE_W < 1 || RPULSE_W > (1 << CW)) begin : g_chk_rpw
      $error("fdc_wd_rd_shaper: RPULSE_W out of range");
   end
   if (RCLK_PER < 4 || (RCLK_PER % 2) != 0 || RCLK_PER >= (1 << CW)) begin : g_chk_per
      $error("fdc_wd_rd_shaper: RCLK_PER must be even, >=4 and fit in CW bits");
   end
   if (DEPTH < 1 || DEPTH > 4) begin : g_chk_depth
      $error("fdc_wd_rd_shaper: DEPTH must be 1..4");
   end

   localparam logic [CW-1:0] C_D_NOM   = CW'(NOM_DLY);
   localparam logic [CW-1:0] C_D_EARLY = CW'(NOM_DLY - PRECOMP);
   localparam logic [CW-1:0] C_D_LATE  = CW'(NOM_DLY + PRECOMP);
   localparam logic [CW-1:0] C_WP_LAST = CW'(WPULSE_W - 1);
   localparam logic [CW-1:0] C_RP_LAST = CW'(RPULSE_W - 1);
   localparam logic [CW-1:0] C_PER_SD  = CW'(RCLK_PER);
   localparam logic [CW-1:0] C_PER_HD  = CW'(RCLK_PER / 2);
   localparam logic [CW-1:0] C_HLF_SD  = CW'(RCLK_PER / 2);
   localparam logic [CW-1:0] C_HLF_HD  = CW'(RCLK_PER / 4);
   localparam logic [CW-1:0] C_QTR_SD  = CW'(RCLK_PER / 4);
   localparam logic [CW-1:0] C_QTR_HD  = CW'(RCLK_PER / 8);

   typedef enum logic [1:0] {
      S_FREE,
      S_DLY,
      S_PULSE
   } slot_t;

   // ---------------- input synchronisers ----------------
   logic r_wd_s1, r_wd_s2, r_wd_s3;
   logic r_rd_s1, r_rd_s2, r_rd_s3;
   logic r_sl_s1, r_sl_s2;
   logic r_sr_s1, r_sr_s2;
   logic r_tr_s1, r_tr_s2;

   always_ff @(posedge clk28) begin
      if (rst) begin
         r_wd_s1 <= 1'b0; r_wd_s2 <= 1'b0; r_wd_s3 <= 1'b0;
         r_rd_s1 <= 1'b1; r_rd_s2 <= 1'b1; r_rd_s3 <= 1'b1;
         r_sl_s1 <= 1'b0; r_sl_s2 <= 1'b0;
         r_sr_s1 <= 1'b0; r_sr_s2 <= 1'b0;
         r_tr_s1 <= 1'b0; r_tr_s2 <= 1'b0;
      end else begin
         r_wd_s1 <= vg_wd;   r_wd_s2 <= r_wd_s1; r_wd_s3 <= r_wd_s2;
         r_rd_s1 <= fd_rdat; r_rd_s2 <= r_rd_s1; r_rd_s3 <= r_rd_s2;
         r_sl_s1 <= vg_sl;   r_sl_s2 <= r_sl_s1;
         r_sr_s1 <= vg_sr;   r_sr_s2 <= r_sr_s1;
         r_tr_s1 <= vg_tr43; r_tr_s2 <= r_tr_s1;
      end
   end

   // The third stage keeps tracking while en=0, so enabling with a line
   // already at its active level never looks like an edge.
   logic w_wd_edge, w_rd_edge;
   assign w_wd_edge = en & r_wd_s2 & ~r_wd_s3;
   assign w_rd_edge = en & ~r_rd_s2 & r_rd_s3;

   logic w_early, w_late;
   logic [CW-1:0] w_dly;
   assign w_early = precomp_en & r_tr_s2 & r_sl_s2 & ~r_sr_s2;
   assign w_late  = precomp_en & r_tr_s2 & r_sr_s2 & ~r_sl_s2;
   assign w_dly   = w_early ? C_D_EARLY : (w_late ? C_D_LATE : C_D_NOM);

   // ---------------- write pulse slots ----------------
   slot_t         r_st       [DEPTH];
   logic [CW-1:0] r_scnt     [DEPTH];
   slot_t         w_st_nxt   [DEPTH];
   logic [CW-1:0] w_scnt_nxt [DEPTH];
   logic          w_all_busy;
   logic          w_load_done;
   logic          w_pulse_nxt;
   logic          r_fd_wdat;
   logic          r_ovf;

   always_comb begin
      w_st_nxt    = r_st;
      w_scnt_nxt  = r_scnt;
      w_all_busy  = 1'b1;
      w_load_done = 1'b0;
      w_pulse_nxt = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_st[i] == S_FREE) w_all_busy = 1'b0;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
         case (r_st[i])
            S_DLY: begin
               if (r_scnt[i] == '0) begin
                  w_st_nxt[i]   = S_PULSE;
                  w_scnt_nxt[i] = C_WP_LAST;
               end else begin
                  w_scnt_nxt[i] = r_scnt[i] - CW'(1);
               end
            end
            S_PULSE: begin
               if (r_scnt[i] == '0) w_st_nxt[i] = S_FREE;
               else                 w_scnt_nxt[i] = r_scnt[i] - CW'(1);
            end
            default: begin
               if (w_wd_edge && !w_load_done) begin
                  w_st_nxt[i]   = S_DLY;
                  w_scnt_nxt[i] = w_dly;
                  w_load_done   = 1'b1;
               end
            end
         endcase
         if (!en) begin
            w_st_nxt[i]   = S_FREE;
            w_scnt_nxt[i] = '0;
         end
         if (w_st_nxt[i] == S_PULSE) w_pulse_nxt = 1'b1;
      end
   end

   // fd_wdat is registered from the next-state OR of all slot pulses, so
   // one slot ending while another starts cannot glitch the output high.
   always_ff @(posedge clk28) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_st[i]   <= S_FREE;
            r_scnt[i] <= '0;
         end
         r_fd_wdat <= 1'b1;
         r_ovf     <= 1'b0;
      end else begin
         r_st      <= w_st_nxt;
         r_scnt    <= w_scnt_nxt;
         r_fd_wdat <= ~w_pulse_nxt;
         r_ovf     <= (w_wd_edge & w_all_busy) | (r_ovf & ~ovf_clr);
      end
   end

   // ---------------- read pulse and read clock window ----------------
   logic          r_rawr;
   logic [CW-1:0] r_rpcnt;
   logic [CW-1:0] r_rcnt;
   logic          r_rclk;
   logic [CW-1:0] w_per, w_half, w_qtr, w_rcnt_nxt;

   assign w_per  = hd ? C_PER_HD : C_PER_SD;
   assign w_half = hd ? C_HLF_HD : C_HLF_SD;
   assign w_qtr  = hd ? C_QTR_HD : C_QTR_SD;

   // Wrapping on ">= P-1" also folds a counter left beyond a freshly
   // shortened period (hd 0->1) back to 0 at the next step.
   always_comb begin
      w_rcnt_nxt = r_rcnt + CW'(1);
      if (!en)                            w_rcnt_nxt = '0;
      else if (w_rd_edge)                 w_rcnt_nxt = w_qtr;
      else if (r_rcnt >= w_per - CW'(1))  w_rcnt_nxt = '0;
   end

   always_ff @(posedge clk28) begin
      if (rst) begin
         r_rawr  <= 1'b0;
         r_rpcnt <= '0;
         r_rcnt  <= '0;
         r_rclk  <= 1'b0;
      end else begin
         r_rcnt <= w_rcnt_nxt;
         r_rclk <= en & (w_rcnt_nxt >= w_half);
         if (!en) begin
            r_rawr  <= 1'b0;
            r_rpcnt <= '0;
         end else if (w_rd_edge) begin
            r_rawr  <= 1'b1;
            r_rpcnt <= C_RP_LAST;
         end else if (r_rawr) begin
            if (r_rpcnt == '0) r_rawr  <= 1'b0;
            else               r_rpcnt <= r_rpcnt - CW'(1);
         end
      end
   end

   assign fd_wdat = r_fd_wdat;
   assign wr_ovf  = r_ovf;
   assign vg_rawr = r_rawr;
   assign vg_rclk = r_rclk;

endmodule

// File: tb/tb_fdc_wd_rd_shaper.sv
// ---------------------------------------------------------------------------
// tb_fdc_wd_rd_shaper
// Directed bench for fdc_wd_rd_shaper with default parameters. Cycle numbers
// count clk28 rising edges; an input driven just after edge c is first
// sampled at edge c+1. Outputs are read 1 ns after each rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fdc_wd_rd_shaper;

   logic clk28 = 1'b0;
   logic rst, en, hd, precomp_en;
   logic vg_wd, vg_sl, vg_sr, vg_tr43;
   logic fd_wdat, fd_rdat, vg_rawr, vg_rclk, wr_ovf, ovf_clr;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int q_fall[$];
   logic prev_fd;

   always #5 clk28 = ~clk28;

   fdc_wd_rd_shaper #(
      .CW(8), .NOM_DLY(16), .PRECOMP(4), .WPULSE_W(14),
      .RPULSE_W(14), .RCLK_PER(112), .DEPTH(2)
   ) dut (
      .clk28(clk28), .rst(rst), .en(en), .hd(hd), .precomp_en(precomp_en),
      .vg_wd(vg_wd), .vg_sl(vg_sl), .vg_sr(vg_sr), .vg_tr43(vg_tr43),
      .fd_wdat(fd_wdat), .fd_rdat(fd_rdat), .vg_rawr(vg_rawr),
      .vg_rclk(vg_rclk), .wr_ovf(wr_ovf), .ovf_clr(ovf_clr)
   );

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk28);
      cyc++;
      #1;
   endtask

   function automatic int calc_d(input logic pen, tr, sl, sr);
      if (pen && tr && sl && !sr) return 12;
      if (pen && tr && sr && !sl) return 20;
      return 16;
   endfunction

   // One 4-tick vg_wd pulse; returns fall latency from first sample and low width.
   task automatic wr_measure(input logic pen, tr, sl, sr, output int lat, output int wid);
      int n, f, r;
      precomp_en = pen; vg_tr43 = tr; vg_sl = sl; vg_sr = sr;
      repeat (4) tick();
      vg_wd = 1'b1;
      n = cyc + 1; f = -1; r = -1;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (k == 4) vg_wd = 1'b0;
         if (f < 0 && fd_wdat == 1'b0) f = cyc;
         else if (f >= 0 && r < 0 && fd_wdat == 1'b1) r = cyc;
      end
      lat = (f < 0) ? -1 : f - n;
      wid = (r < 0) ? -1 : r - f;
   endtask

   // Three vg_wd edges 6 ticks apart (relative cycles 0, 6, 12).
   task automatic wr_burst(input bit clr_at_ovf, output int fall, output int rise,
                           output int lows, output int ovf_at);
      int n, t;
      n = cyc + 1; fall = -1; rise = -1; lows = 0; ovf_at = -1;
      for (int k = 0; k < 80; k++) begin
         t = cyc + 1 - n;
         vg_wd   = (t < 15) && ((t % 6) < 3);
         ovf_clr = clr_at_ovf && (t == 14);
         tick();
         if (fd_wdat == 1'b0) begin
            lows++;
            if (fall < 0) fall = cyc - n;
         end else if (fall >= 0 && rise < 0) begin
            rise = cyc - n;
         end
         if (wr_ovf && ovf_at < 0) ovf_at = cyc - n;
      end
      vg_wd = 1'b0; ovf_clr = 1'b0;
   endtask

   // fd_rdat low lo1 ticks, high gap, low lo2 (lo2=0: single pulse).
   task automatic rd_measure(input int lo1, input int gap, input int lo2,
                             output int lat, output int wid, output int rise1, output int per);
      int r, hi, fl, r1, r2, t;
      logic prev_rc;
      r = cyc + 1; hi = -1; fl = -1; r1 = -1; r2 = -1;
      prev_rc = vg_rclk;
      for (int k = 0; k < 300; k++) begin
         t = cyc + 1 - r;
         fd_rdat = !((t < lo1) || (lo2 > 0 && t >= lo1 + gap && t < lo1 + gap + lo2));
         tick();
         if (hi < 0 && vg_rawr) hi = cyc;
         else if (hi >= 0 && fl < 0 && !vg_rawr) fl = cyc;
         if (!prev_rc && vg_rclk && cyc > r + 2) begin
            if (r1 < 0) r1 = cyc;
            else if (r2 < 0) r2 = cyc;
         end
         prev_rc = vg_rclk;
      end
      fd_rdat = 1'b1;
      lat   = (hi < 0) ? -1 : hi - r;
      wid   = (fl < 0) ? -1 : fl - hi;
      rise1 = (r1 < 0) ? -1 : r1 - r;
      per   = (r2 < 0) ? -1 : r2 - r1;
   endtask

   task automatic tick_mon();
      tick();
      if (prev_fd && !fd_wdat) begin
         if (q_fall.size() == 0) check_eq("mfm_extra_pulse", cyc, -1);
         else check_eq("mfm_fall_cycle", cyc, q_fall.pop_front());
      end
      prev_fd = fd_wdat;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int lat, wid, fall, rise, lows, ovf_at, rise1, per, gap;
      logic m_pen, m_tr, m_sl, m_sr;
      bit seen;

      rst = 1'b1; en = 1'b1; hd = 1'b0; precomp_en = 1'b1;
      vg_wd = 1'b0; vg_sl = 1'b0; vg_sr = 1'b0; vg_tr43 = 1'b0;
      fd_rdat = 1'b1; ovf_clr = 1'b0;
      repeat (3) tick();
      check_eq("rst_fd_wdat", int'(fd_wdat), 1);
      check_eq("rst_vg_rawr", int'(vg_rawr), 0);
      check_eq("rst_vg_rclk", int'(vg_rclk), 0);
      check_eq("rst_wr_ovf", int'(wr_ovf), 0);
      rst = 1'b0;
      repeat (5) tick();

      // Write latency / precompensation table
      wr_measure(1'b1, 1'b0, 1'b0, 1'b0, lat, wid);
      check_eq("nom_lat", lat, 19);
      check_eq("nom_wid", wid, 14);
      wr_measure(1'b1, 1'b0, 1'b1, 1'b0, lat, wid);
      check_eq("outer_sl_lat", lat, 19);
      wr_measure(1'b1, 1'b1, 1'b1, 1'b0, lat, wid);
      check_eq("early_lat", lat, 15);
      check_eq("early_wid", wid, 14);
      wr_measure(1'b1, 1'b1, 1'b0, 1'b1, lat, wid);
      check_eq("late_lat", lat, 23);
      check_eq("late_wid", wid, 14);
      wr_measure(1'b1, 1'b1, 1'b1, 1'b1, lat, wid);
      check_eq("slsr_lat", lat, 19);
      wr_measure(1'b0, 1'b1, 1'b1, 1'b0, lat, wid);
      check_eq("pcoff_lat", lat, 19);
      precomp_en = 1'b1; vg_tr43 = 1'b0; vg_sl = 1'b0; vg_sr = 1'b0;
      repeat (5) tick();

      // Slot buffer: two pulses merge (19..39), third edge dropped
      wr_burst(1'b0, fall, rise, lows, ovf_at);
      check_eq("burst_fall", fall, 19);
      check_eq("burst_rise", rise, 39);
      check_eq("burst_low_ticks", lows, 20);
      check_eq("burst_ovf_cycle", ovf_at, 14);
      ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
      check_eq("ovf_cleared", int'(wr_ovf), 0);
      repeat (5) tick();
      wr_burst(1'b1, fall, rise, lows, ovf_at);
      check_eq("ovf_set_wins", ovf_at, 14);

      // Enable handling
      en = 1'b0; vg_wd = 1'b1;
      repeat (5) tick();
      check_eq("en0_rclk", int'(vg_rclk), 0);
      check_eq("en0_fd_wdat", int'(fd_wdat), 1);
      en = 1'b1; lows = 0;
      repeat (40) begin tick(); if (!fd_wdat) lows++; end
      check_eq("en_rise_no_pulse", lows, 0);
      vg_wd = 1'b0;
      repeat (5) tick();
      vg_wd = 1'b1; repeat (4) tick(); vg_wd = 1'b0; repeat (4) tick();
      en = 1'b0; tick(); en = 1'b1; lows = 0;
      repeat (40) begin tick(); if (!fd_wdat) lows++; end
      check_eq("en0_discard", lows, 0);
      check_eq("ovf_retained", int'(wr_ovf), 1);

      // Reset in the middle of an fd_wdat pulse
      vg_wd = 1'b1; seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         tick();
         if (k == 3) vg_wd = 1'b0;
         if (!fd_wdat) begin seen = 1'b1; break; end
      end
      vg_wd = 1'b0;
      check_eq("rst_pulse_seen", int'(seen), 1);
      repeat (3) tick();
      rst = 1'b1; tick();
      check_eq("rst_mid_fd_wdat", int'(fd_wdat), 1);
      check_eq("rst_mid_wr_ovf", int'(wr_ovf), 0);
      rst = 1'b0; lows = 0;
      repeat (30) begin tick(); if (!fd_wdat) lows++; end
      check_eq("rst_slots_empty", lows, 0);

      // Read path
      rd_measure(5, 0, 0, lat, wid, rise1, per);
      check_eq("rd_lat", lat, 2);
      check_eq("rd_wid", wid, 14);
      check_eq("rclk_rephase_sd", rise1, 30);
      check_eq("rclk_period_sd", per, 112);
      rd_measure(2, 3, 2, lat, wid, rise1, per);
      check_eq("rd_retrig_lat", lat, 2);
      check_eq("rd_retrig_wid", wid, 19);
      check_eq("rclk_retrig_phase", rise1, 35);
      hd = 1'b1;
      repeat (130) tick();
      rd_measure(5, 0, 0, lat, wid, rise1, per);
      check_eq("rd_hd_wid", wid, 14);
      check_eq("rclk_rephase_hd", rise1, 16);
      check_eq("rclk_period_hd", per, 56);
      hd = 1'b0;
      repeat (10) tick();

      // Pseudo-random MFM write stream, edges at least 56 ticks apart
      prev_fd = fd_wdat;
      for (int p = 0; p < 12; p++) begin
         m_pen = 1'($urandom_range(0, 1));
         m_tr  = 1'($urandom_range(0, 1));
         m_sl  = 1'($urandom_range(0, 1));
         m_sr  = 1'($urandom_range(0, 1));
         precomp_en = m_pen; vg_tr43 = m_tr; vg_sl = m_sl; vg_sr = m_sr;
         repeat (3) tick_mon();
         vg_wd = 1'b1;
         q_fall.push_back(cyc + 1 + 3 + calc_d(m_pen, m_tr, m_sl, m_sr));
         repeat (4) tick_mon();
         vg_wd = 1'b0;
         gap = int'($urandom_range(49, 70));
         repeat (gap) tick_mon();
      end
      repeat (40) tick_mon();
      check_eq("mfm_lost_pulses", q_fall.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
